// File: rtl/riscv_v_pkg.sv
// ============================================================================
// Module      : riscv_v_pkg
// Description : Shared types and constants for the vector skid stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_v_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } riscv_v_skid_state_e;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  function automatic logic [1:0] occ_of(input riscv_v_skid_state_e st);
    logic [1:0] occ;
    occ = OCC_EMPTY;
    case (st)
      EMPTY:   occ = OCC_EMPTY;
      ONE:     occ = OCC_ONE;
      FULL:    occ = OCC_FULL;
      default: occ = OCC_EMPTY;
    endcase
    return occ;
  endfunction

endpackage

`default_nettype wire

// File: rtl/riscv_v_sat_counter.sv
// ============================================================================
// Module      : riscv_v_sat_counter
// Description : Up-counter that sticks at all-ones; async active-high reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_v_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (en && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/riscv_v_skid_stage.sv
// ============================================================================
// Module      : riscv_v_skid_stage
// Description : Two-entry elastic valid/ready stage with flush. in_ready and
//               out_valid come straight from flops. Optional stall counter
//               built when RISCV_V_SKID_STALL_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_v_skid_stage
  import riscv_v_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH-1:0]      in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [1:0]                 occupancy,
  output logic [STALL_CNT_WIDTH-1:0] stall_cnt
);

  riscv_v_skid_state_e r_state;
  riscv_v_skid_state_e w_state_nxt;

  logic [DATA_WIDTH-1:0] r_main;
  logic [DATA_WIDTH-1:0] r_skid;
  logic [DATA_WIDTH-1:0] w_main_nxt;
  logic [DATA_WIDTH-1:0] w_skid_nxt;

  logic       r_out_valid;
  logic       r_in_ready;
  logic [1:0] r_occupancy;

  logic w_push;
  logic w_pop;

  assign w_push = in_valid & r_in_ready;
  assign w_pop  = r_out_valid & out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;

    if (flush) begin
      w_state_nxt = EMPTY;
      w_main_nxt  = '0;
      w_skid_nxt  = '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_push) begin
            w_state_nxt = ONE;
            w_main_nxt  = in_data;
          end
        end
        ONE: begin
          if (w_push && !w_pop) begin
            w_state_nxt = FULL;
            w_skid_nxt  = in_data;
          end else if (w_pop && !w_push) begin
            w_state_nxt = EMPTY;
          end else if (w_push && w_pop) begin
            w_main_nxt  = in_data;
          end
        end
        FULL: begin
          // Skid always holds the younger beat, so it moves up on pop.
          if (w_pop) begin
            w_state_nxt = ONE;
            w_main_nxt  = r_skid;
          end
        end
        default: begin
          w_state_nxt = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_occupancy <= OCC_EMPTY;
    end else begin
      r_state     <= w_state_nxt;
      r_main      <= w_main_nxt;
      r_skid      <= w_skid_nxt;
      r_out_valid <= (w_state_nxt != EMPTY);
      r_in_ready  <= (w_state_nxt != FULL);
      r_occupancy <= occ_of(w_state_nxt);
    end
  end

  assign out_valid = r_out_valid;
  assign in_ready  = r_in_ready;
  assign out_data  = r_main;
  assign occupancy = r_occupancy;

`ifdef RISCV_V_SKID_STALL_CNT_EN
  generate
    if (1) begin : g_stall_cnt
      riscv_v_sat_counter #(
        .WIDTH (STALL_CNT_WIDTH)
      ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (r_out_valid & ~out_ready),
        .count (stall_cnt)
      );
    end
  endgenerate
`else
  assign stall_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_riscv_v_skid_stage.sv
// ============================================================================
// Module      : tb_riscv_v_skid_stage
// Description : Vector table, corner sequences and random traffic against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_riscv_v_skid_stage;

  localparam int DW = 32;
  localparam int SW = 4;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [SW-1:0] stall_cnt;

  riscv_v_skid_stage #(
    .DATA_WIDTH      (DW),
    .STALL_CNT_WIDTH (SW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: FIFO of held beats, last presented word, stall count.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_held;
  int            m_stall;

  typedef struct {
    logic          f;
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    logic          e_valid;
    logic          e_ready;
    logic [1:0]    e_occ;
    logic [DW-1:0] e_data;
  } vec_t;

  vec_t vecs[14];

  function automatic void chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int exp_stall();
`ifdef RISCV_V_SKID_STALL_CNT_EN
    return m_stall;
`else
    return 0;
`endif
  endfunction

  task automatic check_model(input string tag);
    chk({tag, ".out_valid"}, DW'(out_valid), DW'(q.size() > 0));
    chk({tag, ".in_ready"},  DW'(in_ready),  DW'(q.size() < 2));
    chk({tag, ".occupancy"}, DW'(occupancy), DW'(q.size()));
    chk({tag, ".out_data"},  out_data,       m_held);
    chk({tag, ".stall_cnt"}, DW'(stall_cnt), DW'(exp_stall()));
  endtask

  task automatic model_reset();
    q.delete();
    m_held  = '0;
    m_stall = 0;
  endtask

  // One clock: drive, check model before the edge, then advance the model.
  task automatic cycle(input logic f, input logic iv, input logic [DW-1:0] d, input logic ordy);
    bit do_pop, do_push;
    flush = f; in_valid = iv; in_data = d; out_ready = ordy;
    @(negedge clk);
    check_model("cyc");
    do_pop  = (q.size() > 0) && ordy;
    do_push = iv && (q.size() < 2);
    if ((q.size() > 0) && !ordy && (m_stall < (1 << SW) - 1)) m_stall++;
    @(posedge clk);
    #1;
    if (f) begin
      q.delete();
      m_held = '0;
    end else begin
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(d);
      if (q.size() > 0) m_held = q[0];
    end
  endtask

  task automatic apply_reset_mid_cycle();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst.out_valid", DW'(out_valid), '0);
    chk("arst.in_ready",  DW'(in_ready),  DW'(1));
    chk("arst.occupancy", DW'(occupancy), '0);
    chk("arst.out_data",  out_data,       '0);
    chk("arst.stall_cnt", DW'(stall_cnt), '0);
    model_reset();
    flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    model_reset();

    vecs[0]  = '{1'b0, 1'b1, 32'h11, 1'b1, 1'b1, 1'b1, 2'd1, 32'h11};
    vecs[1]  = '{1'b0, 1'b1, 32'h22, 1'b1, 1'b1, 1'b1, 2'd1, 32'h22};
    vecs[2]  = '{1'b0, 1'b1, 32'h33, 1'b1, 1'b1, 1'b1, 2'd1, 32'h33};
    vecs[3]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 2'd0, 32'h33};
    vecs[4]  = '{1'b0, 1'b1, 32'h0A, 1'b0, 1'b1, 1'b1, 2'd1, 32'h0A};
    vecs[5]  = '{1'b0, 1'b1, 32'h0B, 1'b0, 1'b1, 1'b0, 2'd2, 32'h0A};
    vecs[6]  = '{1'b0, 1'b1, 32'h0C, 1'b0, 1'b1, 1'b0, 2'd2, 32'h0A};
    vecs[7]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 2'd1, 32'h0B};
    vecs[8]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 2'd0, 32'h0B};
    vecs[9]  = '{1'b0, 1'b1, 32'h01, 1'b0, 1'b1, 1'b1, 2'd1, 32'h01};
    vecs[10] = '{1'b0, 1'b1, 32'h02, 1'b0, 1'b1, 1'b0, 2'd2, 32'h01};
    vecs[11] = '{1'b1, 1'b1, 32'h03, 1'b1, 1'b0, 1'b1, 2'd0, 32'h00};
    vecs[12] = '{1'b0, 1'b1, 32'h44, 1'b1, 1'b1, 1'b1, 2'd1, 32'h44};
    vecs[13] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 2'd0, 32'h44};

    #1;
    chk("rst.out_valid", DW'(out_valid), '0);
    chk("rst.in_ready",  DW'(in_ready),  DW'(1));
    chk("rst.occupancy", DW'(occupancy), '0);
    chk("rst.out_data",  out_data,       '0);
    chk("rst.stall_cnt", DW'(stall_cnt), '0);
    #6;
    rst = 1'b0;

    // Directed table: streaming, backpressure, flush priority.
    for (int i = 0; i < 14; i++) begin
      cycle(vecs[i].f, vecs[i].iv, vecs[i].d, vecs[i].ordy);
      chk($sformatf("vec%0d.out_valid", i), DW'(out_valid), DW'(vecs[i].e_valid));
      chk($sformatf("vec%0d.in_ready", i),  DW'(in_ready),  DW'(vecs[i].e_ready));
      chk($sformatf("vec%0d.occupancy", i), DW'(occupancy), DW'(vecs[i].e_occ));
      chk($sformatf("vec%0d.out_data", i),  out_data,       vecs[i].e_data);
    end

    // Async reset while full, then accept on the first cycle after release.
    cycle(1'b0, 1'b1, 32'hA1, 1'b0);
    cycle(1'b0, 1'b1, 32'hA2, 1'b0);
    chk("pre_arst.occupancy", DW'(occupancy), DW'(2));
    apply_reset_mid_cycle();
    cycle(1'b0, 1'b1, 32'hB1, 1'b1);
    chk("post_arst.accept", out_data, 32'hB1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // Stall saturation: 20 stalled cycles on a 4-bit counter.
    apply_reset_mid_cycle();
    cycle(1'b0, 1'b1, 32'h55, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0);
`ifdef RISCV_V_SKID_STALL_CNT_EN
    chk("stall.sat", DW'(stall_cnt), DW'(15));
`else
    chk("stall.off", DW'(stall_cnt), DW'(0));
`endif
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);

    // Random traffic from a clean state.
    apply_reset_mid_cycle();
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 15) == 0), 1'(($urandom & 3) != 0), DW'($urandom),
            1'(($urandom & 3) != 0));
    end
    for (int i = 0; i < 30; i++) begin
      cycle(1'b0, 1'(($urandom & 1) != 0), DW'($urandom), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
